fnd_scan_controller: RTL and testbench

- Sequences the shared 7-segment decoder across a 4-digit multiplexed common-anode FND bank that shows the rhythm-game score.
- Accepts a binary score with a load strobe and converts it to four BCD digits with a sequential shift-add-3 (double-dabble) engine.
- Holds the converted digits in a display register and time-multiplexes them onto the single bcd_out nibble, which feeds the decoder, while driving the digit-select lines.
- Optionally blanks leading zeros by driving the decoder's off-code.

---
 rtl/fnd_scan_if.sv | 20 ++
 rtl/fnd_scan_controller.sv | 124 ++++++++++++
 tb/tb_fnd_scan_controller.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/fnd_scan_if.sv
// Signal bundle between the score source and the FND scan controller.
// The master drives the score and strobes; the slave returns busy and the scanned digit.
interface fnd_scan_if;
  logic [13:0] value;
  logic        load;
  logic        blank_lz;
  logic        busy;
  logic [3:0]  bcd_out;
  logic [3:0]  digit_sel;

  modport master (
    output value, load, blank_lz,
    input  busy, bcd_out, digit_sel
  );

  modport slave (
    input  value, load, blank_lz,
    output busy, bcd_out, digit_sel
  );
endinterface

// File: rtl/fnd_scan_controller.sv
// Converts a binary score to BCD with a sequential double-dabble engine and
// time-multiplexes the four digits onto one decoder nibble with optional leading-zero blanking.
module fnd_scan_controller #(
  parameter int SCAN_DIV = 1000,
  parameter int CNT_W    = 10
) (
  input logic        clk,
  input logic        rst,
  fnd_scan_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t       state_q, state_nx;
  logic [13:0]  bin_q, bin_nx;
  logic [15:0]  acc_q, acc_nx;
  logic [3:0]   step_q, step_nx;
  logic [15:0]  disp_q, disp_nx;
  logic         pend_q, pend_nx;
  logic [13:0]  lat_q, lat_nx;
  logic         busy_q;
  logic [CNT_W-1:0] presc_q;
  logic [1:0]   idx_q;
  logic [15:0]  adj;
  logic         blank;

  function automatic logic [13:0] sat(input logic [13:0] v);
    return (v > 14'd9999) ? 14'd9999 : v;
  endfunction

  // Add-3 correction on every nibble that would overflow a decimal digit after the shift.
  always_comb begin
    adj = acc_q;
    for (int k = 0; k < 4; k++) begin
      if (acc_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
    state_nx = state_q;
    bin_nx   = bin_q;
    acc_nx   = acc_q;
    step_nx  = step_q;
    disp_nx  = disp_q;
    pend_nx  = pend_q;
    lat_nx   = lat_q;
    unique case (state_q)
      IDLE: begin
        if (bus.load || pend_q) begin
          bin_nx   = sat(bus.load ? bus.value : lat_q);
          acc_nx   = 16'd0;
          step_nx  = 4'd0;
          pend_nx  = 1'b0;
          state_nx = CONV;
        end
      end
      CONV: begin
        {acc_nx, bin_nx} = {adj[14:0], bin_q, 1'b0};
        step_nx = step_q + 4'd1;
        if (step_q == 4'd13) state_nx = DONE;
      end
      DONE: begin
        disp_nx = acc_q;
        if (pend_q) begin
          bin_nx   = sat(lat_q);
          acc_nx   = 16'd0;
          step_nx  = 4'd0;
          pend_nx  = 1'b0;
          state_nx = CONV;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    // A load while busy (including the DONE->IDLE edge) only replaces the pending value.
    if (state_q != IDLE && bus.load) begin
      pend_nx = 1'b1;
      lat_nx  = bus.value;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      acc_q   <= '0;
      step_q  <= '0;
      disp_q  <= '0;
      pend_q  <= 1'b0;
      lat_q   <= '0;
      busy_q  <= 1'b0;
      presc_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_nx;
      bin_q   <= bin_nx;
      acc_q   <= acc_nx;
      step_q  <= step_nx;
      disp_q  <= disp_nx;
      pend_q  <= pend_nx;
      lat_q   <= lat_nx;
      busy_q  <= (state_nx != IDLE);
      if (presc_q == CNT_W'(SCAN_DIV - 1)) begin
        presc_q <= '0;
        idx_q   <= idx_q + 2'd1;
      end else begin
        presc_q <= presc_q + 1'b1;
      end
    end
  end

  // Digit k blanks when it and every higher digit are zero; the ones digit always shows.
  always_comb begin
    blank         = bus.blank_lz && (idx_q != 2'd0) && ((disp_q >> {idx_q, 2'b00}) == 16'd0);
    bus.digit_sel = ~(4'b0001 << idx_q);
    bus.bcd_out   = blank ? 4'hF : disp_q[{idx_q, 2'b00} +: 4];
  end

  assign bus.busy = busy_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed bench for fnd_scan_controller with an expected-display scoreboard
// and a decimal reference model independent of the double-dabble engine.
module tb_fnd_scan_controller;

  localparam int SCAN_DIV = 4;
  localparam int CNT_W    = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  logic [15:0] exp_q[$];
  logic [15:0] disp_model = 16'd0;

  fnd_scan_if bus ();

  fnd_scan_controller #(.SCAN_DIV(SCAN_DIV), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    int s;
    s = (v > 9999) ? 9999 : v;
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  function automatic logic [3:0] exp_code(input logic [15:0] d, input int k, input logic blz);
    logic [15:0] hi;
    hi = d >> (4 * k);
    if (k > 0 && blz && hi == 16'd0) return 4'hF;
    return hi[3:0];
  endfunction

  function automatic int sel_idx(input logic [3:0] sel);
    case (sel)
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return 0;
    endcase
  endfunction

  // Wait (bounded) for each digit slot in turn and compare the scanned code.
  task automatic read_display(input string tag, input logic [15:0] d, input logic blz);
    logic [3:0] want_sel;
    int n;
    for (int k = 0; k < 4; k++) begin
      want_sel = ~(4'b0001 << k);
      n = 0;
      while (bus.digit_sel !== want_sel && n < 8 * SCAN_DIV + 4) begin
        @(negedge clk);
        n++;
      end
      if (bus.digit_sel !== want_sel) check({tag, "_scan_timeout"}, {12'd0, bus.digit_sel}, {12'd0, want_sel});
      else check({tag, "_digit"}, {12'd0, bus.bcd_out}, {12'd0, exp_code(d, k, blz)});
    end
  endtask

  task automatic run_conv(input int v, input logic blz, input string tag);
    logic [15:0] old_disp, new_disp;
    logic [3:0]  pre_code;
    int          pre_idx, n;
    old_disp = disp_model;
    pre_code = 4'hx;
    pre_idx  = 0;
    bus.blank_lz = blz;
    bus.value    = 14'(v);
    bus.load     = 1'b1;
    exp_q.push_back(to_bcd(v));
    @(negedge clk);
    bus.load = 1'b0;
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      pre_code = bus.bcd_out;
      pre_idx  = sel_idx(bus.digit_sel);
      n++;
      @(negedge clk);
    end
    new_disp = exp_q.pop_front();
    check({tag, "_busy_cycles"}, 16'(n), 16'd15);
    check({tag, "_hold_pre"}, {12'd0, pre_code}, {12'd0, exp_code(old_disp, pre_idx, blz)});
    check({tag, "_update"}, {12'd0, bus.bcd_out}, {12'd0, exp_code(new_disp, sel_idx(bus.digit_sel), blz)});
    disp_model = new_disp;
    read_display(tag, new_disp, blz);
  endtask

  initial begin
    logic [15:0] first, pend_exp;
    bus.value    = '0;
    bus.load     = 1'b0;
    bus.blank_lz = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", {15'd0, bus.busy}, 16'd0);
    check("rst_sel", {12'd0, bus.digit_sel}, 16'h000E);
    check("rst_bcd", {12'd0, bus.bcd_out}, 16'd0);
    rst = 1'b1;

    // Idle scan: digit advances every SCAN_DIV cycles, all digits show 0
    for (int n = 0; n < 20; n++) begin
      check("idle_sel", {12'd0, bus.digit_sel}, {12'd0, ~(4'b0001 << ((n / SCAN_DIV) % 4))});
      check("idle_bcd", {12'd0, bus.bcd_out}, 16'd0);
      check("idle_busy", {15'd0, bus.busy}, 16'd0);
      @(negedge clk);
    end

    run_conv(1234, 1'b0, "c1234");
    run_conv(16383, 1'b0, "csat");
    run_conv(0, 1'b1, "czero_blz");
    run_conv(40, 1'b1, "c40_blz");

    // Blanking follows blank_lz without waiting for a clock edge
    bus.blank_lz = 1'b0;
    #1;
    check("blz_live", {12'd0, bus.bcd_out}, {12'd0, exp_code(disp_model, sel_idx(bus.digit_sel), 1'b0)});
    read_display("c40_noblz", disp_model, 1'b0);

    // Loads while busy: only the newest pending value is converted
    @(negedge clk);
    bus.value = 14'd1111;
    bus.load  = 1'b1;
    exp_q.push_back(to_bcd(1111));
    pend_exp = 16'd0;
    first    = 16'd0;
    @(negedge clk);
    bus.load = 1'b0;
    for (int e = 0; e <= 30; e++) begin
      check("ml_busy", {15'd0, bus.busy}, (e < 30) ? 16'd1 : 16'd0);
      if (e == 15) begin
        first = exp_q.pop_front();
        exp_q.push_back(pend_exp);
      end
      if (e >= 15 && e < 30)
        check("ml_first", {12'd0, bus.bcd_out}, {12'd0, exp_code(first, sel_idx(bus.digit_sel), 1'b0)});
      if (e == 30) begin
        disp_model = exp_q.pop_front();
        check("ml_second", {12'd0, bus.bcd_out}, {12'd0, exp_code(disp_model, sel_idx(bus.digit_sel), 1'b0)});
      end
      if (e == 4) begin
        bus.value = 14'd2222; bus.load = 1'b1; pend_exp = to_bcd(2222);
      end else if (e == 8) begin
        bus.value = 14'd3333; bus.load = 1'b1; pend_exp = to_bcd(3333);
      end else begin
        bus.load = 1'b0;
      end
      if (e < 30) @(negedge clk);
    end
    read_display("ml", disp_model, 1'b0);

    // Reset mid-conversion aborts it and clears the display
    @(negedge clk);
    bus.value = 14'd5678;
    bus.load  = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("abort_busy", {15'd0, bus.busy}, 16'd0);
    check("abort_sel", {12'd0, bus.digit_sel}, 16'h000E);
    check("abort_bcd", {12'd0, bus.bcd_out}, 16'd0);
    for (int n = 0; n < 24; n++) begin
      @(negedge clk);
      check("abort_idle_busy", {15'd0, bus.busy}, 16'd0);
      check("abort_idle_bcd", {12'd0, bus.bcd_out}, 16'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
